// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the CPU and a debug/loader port.
// One registered access per cycle; synchronous read data is routed back by a 2-stage owner tag.
module data_memory_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_halt,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       s1_valid, s1_dbg;
    logic       s2_valid, s2_dbg;
    logic       any_gnt;
    logic       sel_we;

    // Debug wins when halted, when starved to the limit, or when the CPU is idle.
    always_comb begin
        dbg_gnt   = rst_n & dbg_req & (dbg_halt | (wait_cnt == WAIT_LIMIT) | ~cpu_req);
        cpu_gnt   = rst_n & cpu_req & ~dbg_gnt;
        cpu_stall = rst_n & cpu_req & ~cpu_gnt;
        any_gnt   = cpu_gnt | dbg_gnt;
        sel_we    = dbg_gnt ? dbg_we : cpu_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1_valid  <= 1'b0;
            s1_dbg    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_dbg    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            mem_en <= any_gnt;
            mem_we <= any_gnt & sel_we;
            if (any_gnt) begin
                mem_addr  <= dbg_gnt ? dbg_addr : cpu_addr;
                mem_wdata <= dbg_gnt ? dbg_wdata : cpu_wdata;
            end
            s1_valid <= any_gnt & ~sel_we;
            s1_dbg   <= dbg_gnt;
            s2_valid <= s1_valid;
            s2_dbg   <= s1_dbg;

            // Halt always grants a debug request, so it only needs to block counting.
            if (!dbg_req || dbg_gnt)
                wait_cnt <= '0;
            else if (!dbg_halt && (wait_cnt != WAIT_LIMIT))
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign cpu_rvalid = s2_valid & ~s2_dbg;
    assign dbg_rvalid = s2_valid & s2_dbg;
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a synchronous memory model.
// Read data pattern is addr[7:0] + 0x93, so expected values are fixed constants below.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        dbg_req, dbg_we, dbg_halt;
    logic [10:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [7:0]  dbg_rdata;
    logic        mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [10:0] last_wr_addr;
    logic [7:0]  last_wr_data;
    int          wr_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.ADDR_W(11), .DATA_W(8), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_halt(dbg_halt), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_wdata;
                wr_cnt       <= wr_cnt + 1;
            end else begin
                mem_rdata <= mem_addr[7:0] + 8'h93;
            end
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 1 unit after the rising edge; checks run 1 unit later.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_halt = 0;
    endtask

    initial begin
        wr_cnt = 0;
        last_wr_addr = '0;
        last_wr_data = '0;
        mem_rdata = '0;
        idle_inputs();
        rst_n = 0;
        cpu_req = 1;
        dbg_req = 1;
        #12;
        chk_val("rst_cpu_gnt", 32'(cpu_gnt), 0);
        chk_val("rst_dbg_gnt", 32'(dbg_gnt), 0);
        chk_val("rst_stall", 32'(cpu_stall), 0);
        chk_val("rst_mem_en", 32'(mem_en), 0);
        chk_val("rst_mem_addr", 32'(mem_addr), 0);
        chk_val("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 0);
        idle_inputs();
        #6 rst_n = 1;

        // CPU read alone
        next_cyc();
        cpu_req = 1; cpu_addr = 11'h012;
        #1;
        chk_val("rd_cpu_gnt", 32'(cpu_gnt), 1);
        chk_val("rd_cpu_stall", 32'(cpu_stall), 0);
        next_cyc();
        cpu_req = 0;
        #1;
        chk_val("rd_mem_en", 32'(mem_en), 1);
        chk_val("rd_mem_we", 32'(mem_we), 0);
        chk_val("rd_mem_addr", 32'(mem_addr), 32'h012);
        chk_val("rd_early_rvalid", 32'(cpu_rvalid), 0);
        next_cyc(); #1;
        chk_val("rd_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk_val("rd_cpu_rdata", 32'(cpu_rdata), 32'hA5);
        chk_val("rd_dbg_rvalid", 32'(dbg_rvalid), 0);
        next_cyc(); #1;
        chk_val("rd_rvalid_pulse", 32'(cpu_rvalid), 0);
        chk_val("rd_mem_en_idle", 32'(mem_en), 0);

        // Contention: debug forced in on the 5th cycle
        for (int c = 0; c < 8; c++) begin
            next_cyc();
            cpu_req = (c < 6); cpu_addr = 11'h040;
            dbg_req = (c < 6); dbg_addr = 11'h030;
            #1;
            chk_val($sformatf("ct_cpu_gnt%0d", c), 32'(cpu_gnt), 32'((c < 6) && (c != 4)));
            chk_val($sformatf("ct_dbg_gnt%0d", c), 32'(dbg_gnt), 32'(c == 4));
            chk_val($sformatf("ct_stall%0d", c), 32'(cpu_stall), 32'(c == 4));
            if (c >= 2) begin
                chk_val($sformatf("ct_cpu_rv%0d", c), 32'(cpu_rvalid), 32'(c != 6));
                chk_val($sformatf("ct_dbg_rv%0d", c), 32'(dbg_rvalid), 32'(c == 6));
            end
        end
        next_cyc(); idle_inputs(); next_cyc(); next_cyc();

        // Halt mode: two debug writes with the CPU requesting
        wr_cnt = 0;
        dbg_halt = 1; cpu_req = 1; cpu_addr = 11'h100;
        dbg_req = 1; dbg_we = 1; dbg_addr = 11'h7FF; dbg_wdata = 8'h5A;
        #1;
        chk_val("ht_dbg_gnt0", 32'(dbg_gnt), 1);
        chk_val("ht_cpu_gnt0", 32'(cpu_gnt), 0);
        chk_val("ht_stall0", 32'(cpu_stall), 1);
        next_cyc();
        dbg_addr = 11'h7FE; dbg_wdata = 8'h3C;
        #1;
        chk_val("ht_mem_en", 32'(mem_en), 1);
        chk_val("ht_mem_we", 32'(mem_we), 1);
        chk_val("ht_mem_addr", 32'(mem_addr), 32'h7FF);
        chk_val("ht_mem_wdata", 32'(mem_wdata), 32'h5A);
        chk_val("ht_dbg_gnt1", 32'(dbg_gnt), 1);
        chk_val("ht_stall1", 32'(cpu_stall), 1);
        next_cyc();
        idle_inputs();
        #1;
        chk_val("ht_mem_addr2", 32'(mem_addr), 32'h7FE);
        chk_val("ht_mem_wdata2", 32'(mem_wdata), 32'h3C);
        next_cyc(); #1;
        chk_val("ht_no_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 0);
        chk_val("ht_wr_cnt", 32'(wr_cnt), 2);
        chk_val("ht_last_wr", 32'({last_wr_addr, last_wr_data}), 32'({11'h7FE, 8'h3C}));
        next_cyc(); #1;
        chk_val("ht_no_rvalid2", 32'({cpu_rvalid, dbg_rvalid}), 0);

        // Routing: CPU read then debug read
        next_cyc();
        cpu_req = 1; cpu_addr = 11'h010;
        #1;
        chk_val("rt_cpu_gnt", 32'(cpu_gnt), 1);
        next_cyc();
        cpu_req = 0; dbg_req = 1; dbg_addr = 11'h020;
        #1;
        chk_val("rt_dbg_gnt", 32'(dbg_gnt), 1);
        next_cyc();
        dbg_req = 0;
        #1;
        chk_val("rt_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk_val("rt_cpu_rdata", 32'(cpu_rdata), 32'hA3);
        chk_val("rt_dbg_rvalid0", 32'(dbg_rvalid), 0);
        next_cyc(); #1;
        chk_val("rt_dbg_rvalid", 32'(dbg_rvalid), 1);
        chk_val("rt_dbg_rdata", 32'(dbg_rdata), 32'hB3);
        chk_val("rt_cpu_rvalid1", 32'(cpu_rvalid), 0);
        next_cyc(); idle_inputs(); next_cyc();

        // Reset mid-read with a partly starved debug port
        for (int c = -1; c < 7; c++) begin
            next_cyc();
            cpu_req = 1; cpu_addr = 11'h012;
            dbg_req = 1; dbg_addr = 11'h030;
            if (c == 1) rst_n = 0;
            if (c == 2) rst_n = 1;
            #1;
            if (c == 1) chk_val("mr_mem_en", 32'(mem_en), 0);
            if (c == 2 || c == 3) chk_val($sformatf("mr_rvalid%0d", c), 32'(cpu_rvalid), 0);
            chk_val($sformatf("mr_cpu_gnt%0d", c), 32'(cpu_gnt), 32'(c != 1 && c != 6));
            chk_val($sformatf("mr_dbg_gnt%0d", c), 32'(dbg_gnt), 32'(c == 6));
        end
        next_cyc(); idle_inputs(); next_cyc(); next_cyc();

        // Withdraw: dropping dbg_req restarts the starvation count
        for (int c = 0; c < 9; c++) begin
            next_cyc();
            cpu_req = 1; cpu_addr = 11'h050;
            dbg_req = (c != 2); dbg_addr = 11'h060;
            #1;
            chk_val($sformatf("wd_dbg_gnt%0d", c), 32'(dbg_gnt), 32'(c == 7));
            chk_val($sformatf("wd_cpu_gnt%0d", c), 32'(cpu_gnt), 32'(c != 7));
        end
        next_cyc(); idle_inputs(); next_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
